mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit controller for the E stage of the pipelined CPU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and holds busy for a fixed latency. Commits HI/LO at completion.
- Produces the stall request the hazard unit uses to freeze D when a later mult/div/mf/mt instruction would collide.
- Result values are computed internally. The fixed latency models the hardware unit's timing.

---
 rtl/mdu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage: fixed-latency busy window,
// HI/LO committed at completion, and a D-stage stall request for MDU hazards.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_use_MDU,
  output logic        busy,
  output logic        stall_MDU,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic [31:0]        hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic               pend_wr_r;

  logic               is_mdv_s, is_div_s, is_signed_s;
  logic [63:0]        ext_a_s, ext_b_s, prod_s;
  logic               a_neg_s, b_neg_s;
  logic [31:0]        abs_a_s, abs_b_s, divisor_s, uq_s, ur_s, quot_s, rem_s;
  logic [31:0]        res_hi_s, res_lo_s;
  logic               res_wr_s;

  // Decode and compute the result an accepted mult/div op will commit.
  always_comb begin
    is_mdv_s    = (MDUop == OP_MULT) || (MDUop == OP_MULTU) ||
                  (MDUop == OP_DIV)  || (MDUop == OP_DIVU);
    is_div_s    = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
    is_signed_s = (MDUop == OP_MULT) || (MDUop == OP_DIV);

    if (is_signed_s) begin
      ext_a_s = {{32{A[31]}}, A};
      ext_b_s = {{32{B[31]}}, B};
    end else begin
      ext_a_s = {32'd0, A};
      ext_b_s = {32'd0, B};
    end
    prod_s = ext_a_s * ext_b_s;

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_neg_s   = (MDUop == OP_DIV) && A[31];
    b_neg_s   = (MDUop == OP_DIV) && B[31];
    abs_a_s   = a_neg_s ? (32'd0 - A) : A;
    abs_b_s   = b_neg_s ? (32'd0 - B) : B;
    divisor_s = (B == 32'd0) ? 32'd1 : abs_b_s;
    uq_s      = abs_a_s / divisor_s;
    ur_s      = abs_a_s % divisor_s;
    quot_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
    rem_s     = a_neg_s ? (32'd0 - ur_s) : ur_s;

    if (is_div_s) begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
      res_wr_s = (B != 32'd0);
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
      res_wr_s = 1'b1;
    end
  end

  // Controller FSM: accepts ops in IDLE, counts down in RUN, commits HI/LO on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            case (MDUop)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                pend_hi_r <= res_hi_s;
                pend_lo_r <= res_lo_s;
                pend_wr_r <= res_wr_s;
                cnt_r     <= is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy_r    <= 1'b1;
                state_r   <= RUN;
              end
              OP_MTHI: hi_r <= A;
              OP_MTLO: lo_r <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_r == CNT_W'(1)) begin
            if (pend_wr_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign stall_MDU = D_use_MDU & (busy_r | (start & is_mdv_s));

  mdu_ctrl_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUop (MDUop),
    .busy  (busy_r)
  );

endmodule

// Simulation-only observer: flags any MDU op presented while the unit is busy.
module mdu_ctrl_chk (
  input logic       clk,
  input logic       reset,
  input logic       start,
  input logic [2:0] MDUop,
  input logic       busy
);

  // Upstream stalling should make a start during busy impossible.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && start && (MDUop != 3'b000) && (MDUop != 3'b111)))
        else $info("mdu_ctrl: op %0d presented while busy, ignored", MDUop);
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: cycle-indexed reference model plus literal spot checks.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUop;
  logic [31:0] A, B;
  logic        D_use_MDU;
  logic        busy, stall_MDU;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic cmp_on = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDUop     (MDUop),
    .A         (A),
    .B         (B),
    .D_use_MDU (D_use_MDU),
    .busy      (busy),
    .stall_MDU (stall_MDU),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers: returns {HI, LO}.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 32'd0) res = {32'(ua % ub), 32'(ua / ub)};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Model: the op accepted when cycle index is k keeps busy high through cycle k+N,
  // and its result becomes visible from cycle k+N+1.
  int          cyc, done_at;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwr;
  logic        m_busy;
  assign m_busy = (cyc < done_at);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; done_at <= 0; m_hi <= 32'd0; m_lo <= 32'd0; m_pwr <= 1'b0;
      m_phi <= 32'd0; m_plo <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if ((cyc + 1 == done_at) && m_pwr) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end else if (start && MDUop >= 3'd1 && MDUop <= 3'd4) begin
        done_at <= cyc + 1 + ((MDUop >= 3'd3) ? 10 : 5);
        {m_phi, m_plo} <= ref_res(MDUop, A, B);
        m_pwr <= !((MDUop >= 3'd3) && (B == 32'd0));
      end else if (start && MDUop == 3'd5) begin
        m_hi <= A;
      end else if (start && MDUop == 3'd6) begin
        m_lo <= A;
      end
    end
  end

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      chk("stall_MDU", {31'd0, stall_MDU},
          {31'd0, D_use_MDU & (m_busy | (start & (MDUop >= 3'd1) & (MDUop <= 3'd4)))});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDUop = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; MDUop = 3'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUop = 3'd0; A = 32'd0; B = 32'd0; D_use_MDU = 1'b0;
    cmp_on = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // D-stage user with idle unit and no start must not stall.
    D_use_MDU = 1'b1; #1;
    chk("stall_idle", {31'd0, stall_MDU}, 32'd0);

    // mult -2 * 3 with a D-stage MDU user: stall in the start cycle itself.
    start = 1'b1; MDUop = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3; #1;
    chk("stall_start", {31'd0, stall_MDU}, 32'd1);
    chk("busy_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; MDUop = 3'd0;
    cycles(4);
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    D_use_MDU = 1'b0; #1;
    chk("stall_nouse", {31'd0, stall_MDU}, 32'd0);
    cycles(1);
    chk("mult_busy_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    cycles(5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    cycles(9);
    chk("div_busy_last", {31'd0, busy}, 32'd1);
    cycles(1);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd0);
    cycles(10);
    chk("divz_hi", HI, 32'hFFFF_FFFF);
    chk("divz_lo", LO, 32'hFFFF_FFFD);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    cycles(10);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    issue(3'd4, 32'd100, 32'd7);
    cycles(10);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    cycles(10);
    chk("div_neg_lo", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", HI, 32'd1);

    issue(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    cycles(5);
    chk("mult_max_hi", HI, 32'h3FFF_FFFF);
    chk("mult_max_lo", LO, 32'h0000_0001);

    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi", HI, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo", LO, 32'hCAFE_F00D);

    // Ops 000 and 111 with start do nothing.
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", HI, 32'h1234_5678);

    // Starts while busy are ignored: mthi and a second mult.
    issue(3'd2, 32'd6, 32'd7);
    issue(3'd5, 32'hAAAA_AAAA, 32'd0);
    issue(3'd1, 32'd9, 32'd9);
    chk("ign_hi", HI, 32'h1234_5678);
    cycles(3);
    chk("ign_done_hi", HI, 32'd0);
    chk("ign_done_lo", LO, 32'd42);
    cycles(6);
    chk("ign_no_second", LO, 32'd42);

    // Async reset on cycle 3 of a divide: immediate clear, no later commit.
    issue(3'd6, 32'h5555_5555, 32'd0);
    issue(3'd4, 32'd50, 32'd5);
    cycles(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    cycles(1);
    reset = 1'b0;
    cycles(12);
    chk("arst_no_commit", LO, 32'd0);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
